// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the single-port memory controller: FSM state
// encodings, mem_len codes, reset/write polarity constants and the
// length-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  localparam logic [1:0]  LEN_BYTE      = 2'b00;
  localparam logic [1:0]  LEN_HALF      = 2'b01;
  localparam logic [1:0]  LEN_WORD      = 2'b10;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  // Which requester owns the transfer in flight.
  localparam logic        SRC_IF        = 1'b0;
  localparam logic        SRC_MEM       = 1'b1;

  // Number of RAM byte transfers for a mem_len code; 2'b11 behaves as a word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      LEN_WORD: n = 3'd4;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port memory controller: arbitrates IF fetches and MEM loads/stores
// onto one byte-wide RAM port, sequences 1/2/4-byte transfers and assembles
// or splits 32-bit words.
// Optional feature: define MEM_CTRL_IF_FLUSH_EN to add the if_flush input,
// which cancels an in-flight fetch and blocks fetch acceptance in IDLE.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MEM_CTRL_IF_FLUSH_EN
  input  logic              if_flush,
`endif
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_r,     state_s;
  logic              src_r,       src_s;
  logic [2:0]        n_r,         n_s;
  logic [2:0]        cnt_r,       cnt_s;
  logic [DATA_W-1:0] wdata_r,     wdata_s;
  logic [DATA_W-1:0] buf_r,       buf_s;
  logic [ADDR_W-1:0] ram_a_r,     ram_a_s;
  logic [7:0]        ram_dout_r,  ram_dout_s;
  logic              ram_wr_r,    ram_wr_s;
  logic              if_done_r,   if_done_s;
  logic              mem_done_r,  mem_done_s;
  logic [DATA_W-1:0] if_inst_r,   if_inst_s;
  logic [DATA_W-1:0] mem_rdata_r, mem_rdata_s;

  logic              flush_s;
  logic [1:0]        rd_idx_s;
  logic [1:0]        wr_idx_s;

`ifdef MEM_CTRL_IF_FLUSH_EN
  assign flush_s = if_flush;
`else
  assign flush_s = 1'b0;
`endif

  // A read captures the byte addressed one cycle earlier, so the byte lane
  // trails the counter by one; a write prepares the lane after the current one.
  assign rd_idx_s = cnt_r[1:0] - 2'd1;
  assign wr_idx_s = cnt_r[1:0] + 2'd1;

  assign if_inst      = if_inst_r;
  assign if_done      = if_done_r;
  assign mem_rdata    = mem_rdata_r;
  assign mem_done     = mem_done_r;
  assign ram_a        = ram_a_r;
  assign ram_dout     = ram_dout_r;
  assign ram_wr       = ram_wr_r;
  assign stallreq_if  = if_req & ~if_done_r;
  assign stallreq_mem = mem_req & ~mem_done_r;
  assign busy         = (state_r != ST_IDLE);

  // Next-state, arbitration and datapath update for the transfer sequencer.
  always_comb begin
    state_s     = state_r;
    src_s       = src_r;
    n_s         = n_r;
    cnt_s       = cnt_r;
    wdata_s     = wdata_r;
    buf_s       = buf_r;
    ram_a_s     = ram_a_r;
    ram_dout_s  = ram_dout_r;
    ram_wr_s    = WRITE_DISABLE;
    if_done_s   = 1'b0;
    mem_done_s  = 1'b0;
    if_inst_s   = if_inst_r;
    mem_rdata_s = mem_rdata_r;

    case (state_r)
      ST_IDLE: begin
        if (if_done_r || mem_done_r) begin
          // Completion cycle: the finished requester is dropping its req,
          // so nothing is accepted until the following cycle.
          state_s = ST_IDLE;
        end else if (mem_req) begin
          // MEM holds the older instruction and always wins.
          src_s   = SRC_MEM;
          n_s     = len_to_bytes(mem_len);
          cnt_s   = 3'd0;
          ram_a_s = mem_addr;
          buf_s   = DATA_W'(ZERO_WORD);
          if (mem_we) begin
            state_s    = ST_WRITE;
            wdata_s    = mem_wdata;
            ram_wr_s   = WRITE_ENABLE;
            ram_dout_s = mem_wdata[7:0];
          end else begin
            state_s    = ST_READ;
          end
        end else if (if_req && !flush_s) begin
          src_s   = SRC_IF;
          n_s     = 3'd4;
          cnt_s   = 3'd0;
          ram_a_s = if_addr;
          buf_s   = DATA_W'(ZERO_WORD);
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_READ: begin
        if ((src_r == SRC_IF) && flush_s) begin
          // Cancelled fetch: drop the partial word, no completion pulse.
          state_s = ST_IDLE;
          cnt_s   = 3'd0;
        end else begin
          if (cnt_r != 3'd0) begin
            buf_s[{rd_idx_s, 3'b000} +: 8] = ram_din;
          end else begin
            buf_s = buf_r;
          end
          if (cnt_r == n_r) begin
            // Tail cycle: last byte captured, publish the word.
            state_s = ST_IDLE;
            cnt_s   = 3'd0;
            if (src_r == SRC_MEM) begin
              mem_done_s  = 1'b1;
              mem_rdata_s = buf_s;
            end else begin
              if_done_s   = 1'b1;
              if_inst_s   = buf_s;
            end
          end else begin
            cnt_s = cnt_r + 3'd1;
            if (cnt_r < (n_r - 3'd1)) begin
              ram_a_s = ram_a_r + ADDR_ONE;
            end else begin
              ram_a_s = ram_a_r;
            end
          end
        end
      end

      ST_WRITE: begin
        if (cnt_r == (n_r - 3'd1)) begin
          // Last byte is on the port this cycle.
          state_s    = ST_IDLE;
          cnt_s      = 3'd0;
          mem_done_s = 1'b1;
        end else begin
          cnt_s      = cnt_r + 3'd1;
          ram_a_s    = ram_a_r + ADDR_ONE;
          ram_dout_s = wdata_r[{wr_idx_s, 3'b000} +: 8];
          ram_wr_s   = WRITE_ENABLE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r     <= ST_IDLE;
      src_r       <= SRC_IF;
      n_r         <= 3'd0;
      cnt_r       <= 3'd0;
      wdata_r     <= DATA_W'(ZERO_WORD);
      buf_r       <= DATA_W'(ZERO_WORD);
      ram_a_r     <= {ADDR_W{1'b0}};
      ram_dout_r  <= 8'h00;
      ram_wr_r    <= WRITE_DISABLE;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_inst_r   <= DATA_W'(ZERO_WORD);
      mem_rdata_r <= DATA_W'(ZERO_WORD);
    end else begin
      state_r     <= state_s;
      src_r       <= src_s;
      n_r         <= n_s;
      cnt_r       <= cnt_s;
      wdata_r     <= wdata_s;
      buf_r       <= buf_s;
      ram_a_r     <= ram_a_s;
      ram_dout_r  <= ram_dout_s;
      ram_wr_r    <= ram_wr_s;
      if_done_r   <= if_done_s;
      mem_done_r  <= mem_done_s;
      if_inst_r   <= if_inst_s;
      mem_rdata_r <= mem_rdata_s;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM model, a transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_inst;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'b00;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'h00;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        busy;
  logic        flush_v;
`ifdef MEM_CTRL_IF_FLUSH_EN
  logic        if_flush = 1'b0;
  assign flush_v = if_flush;
`else
  assign flush_v = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MEM_CTRL_IF_FLUSH_EN
    .if_flush(if_flush),
`endif
    .if_req(if_req),
    .if_addr(if_addr),
    .if_inst(if_inst),
    .if_done(if_done),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_len(mem_len),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_done(mem_done),
    .ram_a(ram_a),
    .ram_dout(ram_dout),
    .ram_wr(ram_wr),
    .ram_din(ram_din),
    .stallreq_if(stallreq_if),
    .stallreq_mem(stallreq_mem),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge is the number of the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM, 4 KiB window (address bits [11:0]); one-cycle read latency.
  logic [7:0]  ram [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_a = 12'h0;
  logic [7:0]  pl_d = 8'h00;

  always @(posedge clk) begin
    ram_din <= ram[ram_a[11:0]];
    if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    else if (pl_en) ram[pl_a] <= pl_d;
  end

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram[a[11:0]];
  endfunction

  function automatic int nbytes(input logic [1:0] l);
    return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- Reference model (transaction level) ----------------
  logic        m_act = 1'b0;
  logic        m_mem = 1'b0;
  logic        m_we = 1'b0;
  int          m_n = 0;
  int          m_a = 0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wd = 32'h0;
  logic [31:0] m_data = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  // Per-cycle compare of every DUT output against the timing rules, then model advance.
  always @(negedge clk) begin : model
    int k;
    int n;
    logic e_wr, e_ifd, e_md, e_busy, e_achk;
    logic [31:0] e_a, e_inst, e_rdata, d, t;
    logic [7:0] e_dout;
    if (chk_en) begin
      e_wr = 1'b0; e_ifd = 1'b0; e_md = 1'b0; e_busy = 1'b0; e_achk = 1'b0;
      e_a = 32'h0; e_dout = 8'h00; e_inst = m_inst; e_rdata = m_rdata; k = 0;
      if (m_act) begin
        k = cyc - m_a - 1;
        if (k < m_n) begin
          e_achk = 1'b1; e_a = m_addr + k; e_busy = 1'b1;
        end
        if (m_we) begin
          if (k < m_n) begin e_wr = 1'b1; e_dout = m_wd[8*k +: 8]; end
          else e_md = 1'b1;
        end else begin
          if (k == m_n) e_busy = 1'b1;
          if (k == m_n + 1) begin
            if (m_mem) begin e_md = 1'b1; e_rdata = m_data; end
            else begin e_ifd = 1'b1; e_inst = m_data; end
          end
        end
      end
      chk("ram_wr", {31'h0, ram_wr}, {31'h0, e_wr});
      chk("if_done", {31'h0, if_done}, {31'h0, e_ifd});
      chk("mem_done", {31'h0, mem_done}, {31'h0, e_md});
      chk("busy", {31'h0, busy}, {31'h0, e_busy});
      chk("if_inst", if_inst, e_inst);
      chk("mem_rdata", mem_rdata, e_rdata);
      chk("stallreq_if", {31'h0, stallreq_if}, {31'h0, if_req & ~e_ifd});
      chk("stallreq_mem", {31'h0, stallreq_mem}, {31'h0, mem_req & ~e_md});
      if (e_achk) chk("ram_a", ram_a, e_a);
      if (e_wr) chk("ram_dout", {24'h0, ram_dout}, {24'h0, e_dout});

      if (rst) begin
        m_act <= 1'b0; m_inst <= 32'h0; m_rdata <= 32'h0;
      end else begin
        m_inst <= e_inst; m_rdata <= e_rdata;
        if (m_act) begin
          if (e_md || e_ifd) m_act <= 1'b0;
          else if (!m_mem && flush_v) m_act <= 1'b0;
        end else if (mem_req) begin
          n = nbytes(mem_len); d = 32'h0;
          for (int i = 0; i < n; i++) begin t = mem_addr + i; d[8*i +: 8] = rd(t); end
          m_act <= 1'b1; m_mem <= 1'b1; m_we <= mem_we; m_n <= n; m_a <= cyc;
          m_addr <= mem_addr; m_wd <= mem_wdata; m_data <= d;
        end else if (if_req && !flush_v) begin
          d = 32'h0;
          for (int i = 0; i < 4; i++) begin t = if_addr + i; d[8*i +: 8] = rd(t); end
          m_act <= 1'b1; m_mem <= 1'b0; m_we <= 1'b0; m_n <= 4; m_a <= cyc;
          m_addr <= if_addr; m_wd <= 32'h0; m_data <= d;
        end
      end
    end
  end

  // ---------------- Requester tasks ----------------
  task automatic pl(input logic [31:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a[11:0]; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd, output int lat);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
    lat = 0;
    while (1) begin
      @(posedge clk); #1; lat++;
      if (mem_done) begin mem_req = 1'b0; break; end
      if (lat > 100) begin
        total++; bad++;
        $display("FAIL mem_timeout: got no mem_done expected within 100 cycles");
        mem_req = 1'b0; break;
      end
    end
  endtask

  task automatic do_if(input logic [31:0] a, output int lat);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    lat = 0;
    while (1) begin
      @(posedge clk); #1; lat++;
      if (if_done) begin if_req = 1'b0; break; end
      if (lat > 100) begin
        total++; bad++;
        $display("FAIL if_timeout: got no if_done expected within 100 cycles");
        if_req = 1'b0; break;
      end
    end
  endtask

  // ---------------- Directed scenarios ----------------
  int lat_a, lat_b, lat_c;

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    pl(32'h100, 8'h13); pl(32'h101, 8'h05); pl(32'h102, 8'h10); pl(32'h103, 8'h00);
    pl(32'h202, 8'h5A); pl(32'h203, 8'h5B); pl(32'h302, 8'hEE); pl(32'h303, 8'hEE);
    pl(32'hFFFFFFFE, 8'h11); pl(32'hFFFFFFFF, 8'h80); pl(32'h0, 8'h33); pl(32'h1, 8'h44);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;

    // Fetch of a 4-byte word.
    do_if(32'h100, lat_a);
    chk("fetch_word", if_inst, 32'h00100513);
    chk("fetch_lat", lat_a, 32'd6);

    // Halfword store; neighbouring byte untouched.
    do_mem(1'b1, 2'b01, 32'h200, 32'hAABBCCDD, lat_a);
    chk("st_lat", lat_a, 32'd3);
    @(posedge clk); #1;
    chk("st_b0", {24'h0, rd(32'h200)}, 32'hDD);
    chk("st_b1", {24'h0, rd(32'h201)}, 32'hCC);
    chk("st_b2", {24'h0, rd(32'h202)}, 32'h5A);

    // Simultaneous MEM load and fetch: MEM first, IF the cycle after mem_done.
    fork
      do_mem(1'b0, 2'b01, 32'h200, 32'h0, lat_a);
      do_if(32'h100, lat_b);
    join
    chk("arb_mem_lat", lat_a, 32'd4);
    chk("arb_mem_data", mem_rdata, 32'h0000CCDD);
    chk("arb_if_lat", lat_b, 32'd11);
    chk("arb_if_word", if_inst, 32'h00100513);

    // Back-to-back MEM requests keep the fetch waiting.
    fork
      begin
        do_mem(1'b0, 2'b00, 32'h200, 32'h0, lat_a);
        do_mem(1'b0, 2'b00, 32'h201, 32'h0, lat_c);
      end
      do_if(32'h100, lat_b);
    join
    chk("b2b_data", mem_rdata, 32'h000000CC);
    chk("b2b_if_lat", lat_b, 32'd14);

    // Address wrap at the top of the address space.
    do_mem(1'b0, 2'b00, 32'hFFFFFFFF, 32'h0, lat_a);
    chk("wrap_byte", mem_rdata, 32'h00000080);
    chk("wrap_byte_lat", lat_a, 32'd3);
    do_mem(1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, lat_a);
    chk("wrap_word", mem_rdata, 32'h44338011);

    // mem_len=11 behaves as a word.
    do_mem(1'b1, 2'b11, 32'h400, 32'h0D0C0B0A, lat_a);
    chk("len3_lat", lat_a, 32'd5);
    do_mem(1'b0, 2'b00, 32'h403, 32'h0, lat_a);
    chk("len3_b3", mem_rdata, 32'h0000000D);

    // Reset in the middle of a word store.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h300; mem_wdata = 32'h44332211;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_wr", {31'h0, ram_wr}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_b0", {24'h0, rd(32'h300)}, 32'h11);
    chk("rst_mid_b1", {24'h0, rd(32'h301)}, 32'h22);
    chk("rst_mid_b2", {24'h0, rd(32'h302)}, 32'hEE);
    chk("rst_mid_b3", {24'h0, rd(32'h303)}, 32'hEE);
    do_mem(1'b0, 2'b10, 32'h300, 32'h0, lat_a);
    chk("rst_mid_reload", mem_rdata, 32'hEEEE2211);
    chk("rst_mid_lat", lat_a, 32'd6);

`ifdef MEM_CTRL_IF_FLUSH_EN
    // Flush a fetch in flight, then refetch.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) begin @(posedge clk); #1; end
    if_flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    if_flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    repeat (6) begin @(posedge clk); #1; end
    do_if(32'h100, lat_a);
    chk("flush_refetch", if_inst, 32'h00100513);
    chk("flush_lat", lat_a, 32'd6);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
